// File: rtl/arb_pkg.sv
// Shared helpers for round-robin arbiters: channel-index width and pointer reset rule.
package arb_pkg;

   function automatic int unsigned sel_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Pointer resets to the last channel so channel 0 wins the first search.
   function automatic int unsigned rr_ptr_rst(input int unsigned n);
      return n - 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches ptr+1 .. ptr (wrapping) for the first request.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned SELW = sel_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [SELW-1:0] index,
   output logic            any
);

   always_comb begin
      int unsigned idx;
      grant = '0;
      index = '0;
      any   = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!any && req[SELW'(idx)]) begin
            any                = 1'b1;
            grant[SELW'(idx)]  = 1'b1;
            index              = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// N-channel W-bit round-robin arbitrating mux with a one-entry registered output.
// Define ARB_MUX_LOCK_EN to add in_last/out_last and packet locking.
module arb_mux
   import arb_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N*W-1:0]          in_data,
   input  logic [N-1:0]            in_valid,
   output logic [N-1:0]            in_ready,
`ifdef ARB_MUX_LOCK_EN
   input  logic [N-1:0]            in_last,
   output logic                    out_last,
`endif
   output logic [W-1:0]            out_data,
   output logic [sel_w(N)-1:0]     out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int unsigned SELW = sel_w(N);
   localparam logic [SELW-1:0] PTR_RST = SELW'(rr_ptr_rst(N));

   logic [SELW-1:0] ptr;
   logic [N-1:0]    eligible;
   logic [N-1:0]    grant;
   logic [SELW-1:0] index;
   logic            any;
   logic            load_en;
   logic [W-1:0]    sel_data;

`ifdef ARB_MUX_LOCK_EN
   logic            lock_act;
   logic [SELW-1:0] lock_ch;
   logic            sel_last;

   always_comb begin
      for (int unsigned i = 0; i < N; i++)
         eligible[i] = in_valid[i] & (~lock_act | (SELW'(i) == lock_ch));
   end

   assign sel_last = |(in_last & grant);
`else
   assign eligible = in_valid;
`endif

   rr_pick #(.N(N), .SELW(SELW)) u_pick (
      .req   (eligible),
      .ptr   (ptr),
      .grant (grant),
      .index (index),
      .any   (any)
   );

   assign load_en  = ~out_valid | out_ready;
   assign in_ready = {N{load_en}} & grant;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++)
         sel_data = sel_data | (in_data[i*W +: W] & {W{grant[i]}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= PTR_RST;
`ifdef ARB_MUX_LOCK_EN
         out_last  <= 1'b0;
         lock_act  <= 1'b0;
         lock_ch   <= '0;
`endif
      end else if (load_en) begin
         if (any) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= index;
            ptr       <= index;
`ifdef ARB_MUX_LOCK_EN
            out_last  <= sel_last;
            lock_act  <= ~sel_last;
            lock_ch   <= index;
`endif
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
// Directed self-checking bench for arb_mux (lock checks only when ARB_MUX_LOCK_EN is defined).
module tb_arb_mux;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] D0 = 32'h0A0A_0A0A;
   localparam logic [31:0] D1 = 32'h1111_1111;
   localparam logic [31:0] D2 = 32'hDEAD_BEEF;
   localparam logic [31:0] D3 = 32'h3333_3333;

   // N=4, W=32 instance
   logic [127:0] d4_in_data;
   logic [3:0]   d4_in_valid, d4_in_ready;
   logic [31:0]  d4_out_data;
   logic [1:0]   d4_out_sel;
   logic         d4_out_valid, d4_out_ready;
`ifdef ARB_MUX_LOCK_EN
   logic [3:0]   d4_in_last;
   logic         d4_out_last;
`endif

   arb_mux #(.N(4), .W(32)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (d4_in_data),
      .in_valid  (d4_in_valid),
      .in_ready  (d4_in_ready),
`ifdef ARB_MUX_LOCK_EN
      .in_last   (d4_in_last),
      .out_last  (d4_out_last),
`endif
      .out_data  (d4_out_data),
      .out_sel   (d4_out_sel),
      .out_valid (d4_out_valid),
      .out_ready (d4_out_ready)
   );

   // N=3, W=8 instance for the non-power-of-two wrap
   logic [23:0] d3_in_data;
   logic [2:0]  d3_in_valid, d3_in_ready;
   logic [7:0]  d3_out_data;
   logic [1:0]  d3_out_sel;
   logic        d3_out_valid, d3_out_ready;
`ifdef ARB_MUX_LOCK_EN
   logic [2:0]  d3_in_last;
   logic        d3_out_last;
`endif

   arb_mux #(.N(3), .W(8)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (d3_in_data),
      .in_valid  (d3_in_valid),
      .in_ready  (d3_in_ready),
`ifdef ARB_MUX_LOCK_EN
      .in_last   (d3_in_last),
      .out_last  (d3_out_last),
`endif
      .out_data  (d3_out_data),
      .out_sel   (d3_out_sel),
      .out_valid (d3_out_valid),
      .out_ready (d3_out_ready)
   );

`ifdef ARB_MUX_LOCK_EN
   logic [15:0] d2_in_data;
   logic [1:0]  d2_in_valid, d2_in_ready, d2_in_last;
   logic [7:0]  d2_out_data;
   logic [0:0]  d2_out_sel;
   logic        d2_out_valid, d2_out_ready, d2_out_last;

   arb_mux #(.N(2), .W(8)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (d2_in_data),
      .in_valid  (d2_in_valid),
      .in_ready  (d2_in_ready),
      .in_last   (d2_in_last),
      .out_last  (d2_out_last),
      .out_data  (d2_out_data),
      .out_sel   (d2_out_sel),
      .out_valid (d2_out_valid),
      .out_ready (d2_out_ready)
   );
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0]  valid;
      logic        ready;
      logic [3:0]  exp_ir;
      logic        exp_ov;
      logic [1:0]  exp_sel;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[15];

   initial begin
      // All four valid: 0,1,2,3,0; then single-channel, backpressure, drain, idle.
      vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, D1};
      vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
      vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, D0};
      vecs[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, D2};
      vecs[6]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
      vecs[7]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
      vecs[8]  = '{4'b1011, 1'b0, 4'b0000, 1'b1, 2'd2, D2};
      vecs[9]  = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3, D3};
      vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, D3};
      vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, D3};
      vecs[12] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, D0};
      vecs[13] = '{4'b0010, 1'b0, 4'b0000, 1'b1, 2'd0, D0};
      vecs[14] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, D1};

      d4_in_data  = {D3, D2, D1, D0};
      d4_in_valid = '0;
      d4_out_ready = 1'b0;
      d3_in_data  = {8'h12, 8'h11, 8'h10};
      d3_in_valid = '0;
      d3_out_ready = 1'b0;
`ifdef ARB_MUX_LOCK_EN
      d4_in_last  = '1;
      d3_in_last  = '1;
      d2_in_data  = {8'hB1, 8'hA0};
      d2_in_valid = '0;
      d2_in_last  = '0;
      d2_out_ready = 1'b0;
`endif

      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_ov", 64'(d4_out_valid), 64'd0);
      chk("rst_data", 64'(d4_out_data), 64'd0);
      chk("rst_sel", 64'(d4_out_sel), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         d4_in_valid  = vecs[i].valid;
         d4_out_ready = vecs[i].ready;
         #1;
         chk($sformatf("v%0d_in_ready", i), 64'(d4_in_ready), 64'(vecs[i].exp_ir));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), 64'(d4_out_valid), 64'(vecs[i].exp_ov));
         chk($sformatf("v%0d_out_sel", i), 64'(d4_out_sel), 64'(vecs[i].exp_sel));
         chk($sformatf("v%0d_out_data", i), 64'(d4_out_data), 64'(vecs[i].exp_data));
         @(negedge clk);
      end
      d4_in_valid = '0;

      // N=3: ptr starts at 2, so the search wraps to 0, then 1, then back to 0.
      d3_in_valid  = 3'b011;
      d3_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("n3_%0d_in_ready", i), 64'(d3_in_ready), (i == 1) ? 64'd2 : 64'd1);
         @(posedge clk);
         #1;
         chk($sformatf("n3_%0d_sel", i), 64'(d3_out_sel), (i == 1) ? 64'd1 : 64'd0);
         chk($sformatf("n3_%0d_data", i), 64'(d3_out_data), (i == 1) ? 64'h11 : 64'h10);
         @(negedge clk);
      end
      d3_in_valid = '0;

`ifdef ARB_MUX_LOCK_EN
      // ch0 single beat, then ch1 three-beat packet against held ch0, then ch0, then ch1 locks.
      begin
         logic [1:0] lv [6];
         logic [1:0] ll [6];
         logic       es [6];
         logic       el [6];
         lv = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
         ll = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
         es = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
         el = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
         d2_out_ready = 1'b1;
         for (int i = 0; i < 6; i++) begin
            d2_in_valid = lv[i];
            d2_in_last  = ll[i];
            #1;
            chk($sformatf("lk%0d_in_ready", i), 64'(d2_in_ready), es[i] ? 64'd2 : 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("lk%0d_sel", i), 64'(d2_out_sel), 64'(es[i]));
            chk($sformatf("lk%0d_last", i), 64'(d2_out_last), 64'(el[i]));
            chk($sformatf("lk%0d_data", i), 64'(d2_out_data), es[i] ? 64'hB1 : 64'hA0);
            @(negedge clk);
         end
         d2_in_last   = 2'b00;
         d2_out_ready = 1'b0;
      end
`endif

      // Put a beat in the dut4 register and hold it, then reset asynchronously.
      d4_in_valid  = 4'b0100;
      d4_out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_ov", 64'(d4_out_valid), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_ov", 64'(d4_out_valid), 64'd0);
      chk("arst_data", 64'(d4_out_data), 64'd0);
      chk("arst_sel", 64'(d4_out_sel), 64'd0);
`ifdef ARB_MUX_LOCK_EN
      chk("arst2_ov", 64'(d2_out_valid), 64'd0);
      chk("arst2_last", 64'(d2_out_last), 64'd0);
      chk("arst2_data", 64'(d2_out_data), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      d4_in_valid  = 4'b1111;
      d4_out_ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
      d2_in_valid  = 2'b11;
      d2_out_ready = 1'b1;
`endif
      #1;
      chk("post_rst_in_ready", 64'(d4_in_ready), 64'd1);
`ifdef ARB_MUX_LOCK_EN
      chk("post_rst2_in_ready", 64'(d2_in_ready), 64'd1);
`endif
      @(posedge clk);
      #1;
      chk("post_rst_sel", 64'(d4_out_sel), 64'd0);
      chk("post_rst_data", 64'(d4_out_data), 64'(D0));
`ifdef ARB_MUX_LOCK_EN
      chk("post_rst2_sel", 64'(d2_out_sel), 64'd0);
`endif
      @(negedge clk);
      d4_in_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
